pc_unit: RTL and testbench

Parametrised program-counter unit and successor to the combinational next-PC logic. It owns the architectural PC register and computes the next PC for the branch, jump, jal, jr, trap and eret selects. It also keeps a trap return register (EPC) and a return-address stack (RAS) that checks jr targets. It sits in the fetch stage: it feeds the instruction memory address and takes branch/jump controls from the decode/execute datapath.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_if.sv | 30 +++
 rtl/pc_unit_ras.sv | 54 +++++
 rtl/pc_unit.sv | 94 +++++++++
 tb/tb_pc_unit.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes and
// the sign-extension helper used for branch offsets.
package pc_pkg;

  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_BEQ  = 3'b001;
  localparam logic [2:0] SEL_BNE  = 3'b010;
  localparam logic [2:0] SEL_J    = 3'b011;
  localparam logic [2:0] SEL_JAL  = 3'b100;
  localparam logic [2:0] SEL_JR   = 3'b101;
  localparam logic [2:0] SEL_TRAP = 3'b110;
  localparam logic [2:0] SEL_ERET = 3'b111;

  // Replicates bit w-1 into every higher bit; callers size-cast the result.
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < 64; i++)
      if (i >= w) r[i] = v[6'(w - 1)];
    return r;
  endfunction

endpackage

// File: rtl/pc_if.sv
// Fetch-stage bus between the decode/execute datapath (master) and pc_unit (slave).
interface pc_if #(
  parameter int AW    = 32,
  parameter int IMM_W = 16,
  parameter int JA_W  = 26,
  parameter int DEPTH = 8
);
  logic                     Stall;
  logic [2:0]               nPC_sel;
  logic                     Zero;
  logic [IMM_W-1:0]         Imm;
  logic [JA_W-1:0]          JumpAddr;
  logic [AW-1:0]            BusA;
  logic [AW-1:0]            PC;
  logic [AW-1:0]            NPC;
  logic [AW-1:0]            EPC;
  logic [AW-1:0]            RasTop;
  logic                     RasMiss;
  logic [$clog2(DEPTH):0]   RasCount;

  modport master (
    output Stall, nPC_sel, Zero, Imm, JumpAddr, BusA,
    input  PC, NPC, EPC, RasTop, RasMiss, RasCount
  );

  modport slave (
    input  Stall, nPC_sel, Zero, Imm, JumpAddr, BusA,
    output PC, NPC, EPC, RasTop, RasMiss, RasCount
  );
endinterface

// File: rtl/pc_unit_ras.sv
// Return-address stack: circular buffer that overwrites its oldest entry on
// overflow and ignores pops when empty.
module ras #(
  parameter int AW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [AW-1:0]          push_data,
  output logic [AW-1:0]          top,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = push_data;
      wp_d        = wp_q + PW'(1);
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop && cnt_q != '0) begin
      wp_d  = wp_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    top   = (cnt_q != '0) ? mem_q[wp_q - PW'(1)] : '0;
    count = cnt_q;
  end

endmodule

// File: rtl/pc_unit.sv
// Architectural PC, next-PC select, trap return register and a return-address
// stack that cross-checks jr targets.
module pc_unit
  import pc_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            IMM_W    = 16,
  parameter int            JA_W     = 26,
  parameter int            DEPTH    = 8,
  parameter logic [AW-1:0] RESET_PC = AW'(1),
  parameter logic [AW-1:0] TRAP_PC  = AW'('h20)
) (
  input  logic Clk,
  input  logic Reset,
  pc_if.slave  bus
);
  logic [AW-1:0]          pc_q, pc_d;
  logic [AW-1:0]          epc_q, epc_d;
  logic                   ras_miss_q, ras_miss_d;
  logic [AW-1:0]          pc_plus1, imm_sx, br_tgt, jt, npc;
  logic [AW-1:0]          ras_top;
  logic [$clog2(DEPTH):0] ras_cnt;
  logic                   commit, do_push, do_pop;

  assign pc_plus1 = pc_q + AW'(1);
  assign imm_sx   = AW'(sext(64'(bus.Imm), IMM_W));
  assign br_tgt   = pc_plus1 + imm_sx;

  // Jumps stay within the current region selected by the PC's upper bits.
  if (AW > JA_W) begin : g_jt_cat
    assign jt = {pc_q[AW-1:JA_W], bus.JumpAddr};
  end else begin : g_jt_trunc
    assign jt = bus.JumpAddr[AW-1:0];
  end

  always_comb begin
    case (bus.nPC_sel)
      SEL_BEQ:  npc = bus.Zero  ? br_tgt : pc_plus1;
      SEL_BNE:  npc = !bus.Zero ? br_tgt : pc_plus1;
      SEL_J,
      SEL_JAL:  npc = jt;
      SEL_JR:   npc = bus.BusA;
      SEL_TRAP: npc = TRAP_PC;
      SEL_ERET: npc = epc_q;
      default:  npc = pc_plus1;
    endcase
    if (Reset) npc = RESET_PC;
  end

  assign commit  = !Reset && !bus.Stall;
  assign do_push = commit && bus.nPC_sel == SEL_JAL;
  assign do_pop  = commit && bus.nPC_sel == SEL_JR;

  ras #(.AW(AW), .DEPTH(DEPTH)) u_ras (
    .clk       (Clk),
    .rst       (Reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .count     (ras_cnt)
  );

  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    ras_miss_d = 1'b0;
    if (Reset) begin
      pc_d  = RESET_PC;
      epc_d = '0;
    end else if (commit) begin
      pc_d = npc;
      if (bus.nPC_sel == SEL_TRAP) epc_d = pc_q;
      // Compared against the pre-pop top, so an empty stack always misses.
      if (do_pop) ras_miss_d = (ras_cnt == '0) || (ras_top != bus.BusA);
    end
  end

  always_ff @(posedge Clk) begin
    pc_q       <= pc_d;
    epc_q      <= epc_d;
    ras_miss_q <= ras_miss_d;
  end

  always_comb begin
    bus.PC       = pc_q;
    bus.NPC      = npc;
    bus.EPC      = epc_q;
    bus.RasTop   = ras_top;
    bus.RasMiss  = ras_miss_q;
    bus.RasCount = ras_cnt;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector table plus hand-written RAS overflow/underflow sequence for pc_unit.
module tb_pc_unit;
  import pc_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  pc_if #(.AW(32), .IMM_W(16), .JA_W(26), .DEPTH(8)) bus ();

  pc_unit #(.AW(32), .IMM_W(16), .JA_W(26), .DEPTH(8),
            .RESET_PC(32'd1), .TRAP_PC(32'h20)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [2:0]  sel;
    logic        zero;
    logic [15:0] imm;
    logic [25:0] ja;
    logic [31:0] busa;
    logic [31:0] e_npc;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    logic [31:0] e_top;
    logic [3:0]  e_cnt;
    logic        e_miss;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic stall, logic [2:0] sel, logic zero,
                              logic [15:0] imm, logic [25:0] ja, logic [31:0] busa,
                              logic [31:0] e_npc, logic [31:0] e_pc, logic [31:0] e_epc,
                              logic [31:0] e_top, logic [3:0] e_cnt, logic e_miss);
    vec_t v;
    v.rst = rst; v.stall = stall; v.sel = sel; v.zero = zero; v.imm = imm;
    v.ja = ja; v.busa = busa; v.e_npc = e_npc; v.e_pc = e_pc; v.e_epc = e_epc;
    v.e_top = e_top; v.e_cnt = e_cnt; v.e_miss = e_miss;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic stall, logic [2:0] sel, logic zero,
                       logic [15:0] imm, logic [25:0] ja, logic [31:0] busa);
    Reset        = rst;
    bus.Stall    = stall;
    bus.nPC_sel  = sel;
    bus.Zero     = zero;
    bus.Imm      = imm;
    bus.JumpAddr = ja;
    bus.BusA     = busa;
  endtask

  // Inputs change 1 time unit after the edge; outputs are read 1 unit after the next edge.
  task automatic step(logic rst, logic stall, logic [2:0] sel, logic zero,
                      logic [15:0] imm, logic [25:0] ja, logic [31:0] busa);
    drive(rst, stall, sel, zero, imm, ja, busa);
    @(posedge Clk);
    #1;
  endtask

  task automatic apply(int idx, vec_t v);
    drive(v.rst, v.stall, v.sel, v.zero, v.imm, v.ja, v.busa);
    #1;
    chk($sformatf("v%0d.npc", idx), bus.NPC, v.e_npc);
    @(posedge Clk);
    #1;
    chk($sformatf("v%0d.pc", idx),   bus.PC, v.e_pc);
    chk($sformatf("v%0d.epc", idx),  bus.EPC, v.e_epc);
    chk($sformatf("v%0d.top", idx),  bus.RasTop, v.e_top);
    chk($sformatf("v%0d.cnt", idx),  32'(bus.RasCount), 32'(v.e_cnt));
    chk($sformatf("v%0d.miss", idx), 32'(bus.RasMiss), 32'(v.e_miss));
  endtask

  initial begin
    //              rst stall sel       z  imm       ja      busa           npc            pc             epc  top cnt miss
    vecs.push_back(mk(1, 0, SEL_SEQ,  0, 16'h0,    26'd0,   32'd0,        32'd1,         32'd1,         0,   0, 0, 0));
    vecs.push_back(mk(1, 0, SEL_SEQ,  0, 16'h0,    26'd0,   32'd0,        32'd1,         32'd1,         0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_SEQ,  0, 16'h0,    26'd0,   32'd0,        32'd2,         32'd2,         0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_SEQ,  0, 16'h0,    26'd0,   32'd0,        32'd3,         32'd3,         0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_SEQ,  0, 16'h0,    26'd0,   32'd0,        32'd4,         32'd4,         0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_JAL,  0, 16'h0,    26'd40,  32'd0,        32'd40,        32'd40,        0,   5, 1, 0));
    vecs.push_back(mk(0, 0, SEL_JR,   0, 16'h0,    26'd0,   32'd5,        32'd5,         32'd5,         0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_JR,   0, 16'h0,    26'd0,   32'd5,        32'd5,         32'd5,         0,   0, 0, 1));
    vecs.push_back(mk(0, 0, SEL_J,    0, 16'h0,    26'd10,  32'd0,        32'd10,        32'd10,        0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_BEQ,  1, 16'hFFFD, 26'd0,   32'd0,        32'd8,         32'd8,         0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_J,    0, 16'h0,    26'd10,  32'd0,        32'd10,        32'd10,        0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_BEQ,  0, 16'hFFFD, 26'd0,   32'd0,        32'd11,        32'd11,        0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_BNE,  0, 16'd5,    26'd0,   32'd0,        32'd17,        32'd17,        0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_TRAP, 0, 16'h0,    26'd0,   32'd0,        32'h20,        32'h20,        17,  0, 0, 0));
    vecs.push_back(mk(0, 1, SEL_ERET, 0, 16'h0,    26'd0,   32'd0,        32'd17,        32'h20,        17,  0, 0, 0));
    vecs.push_back(mk(0, 1, SEL_ERET, 0, 16'h0,    26'd0,   32'd0,        32'd17,        32'h20,        17,  0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_ERET, 0, 16'h0,    26'd0,   32'd0,        32'd17,        32'd17,        17,  0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_BNE,  1, 16'd5,    26'd0,   32'd0,        32'd18,        32'd18,        17,  0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_JR,   0, 16'h0,    26'd0,   32'hFFFFFFFF, 32'hFFFFFFFF,  32'hFFFFFFFF,  17,  0, 0, 1));
    vecs.push_back(mk(0, 0, SEL_SEQ,  0, 16'h0,    26'd0,   32'd0,        32'd0,         32'd0,         17,  0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_JAL,  0, 16'h0,    26'd100, 32'd0,        32'd100,       32'd100,       17,  1, 1, 0));
    vecs.push_back(mk(0, 1, SEL_JAL,  0, 16'h0,    26'd200, 32'd0,        32'd200,       32'd100,       17,  1, 1, 0));
    vecs.push_back(mk(1, 1, SEL_JAL,  0, 16'h0,    26'd200, 32'd0,        32'd1,         32'd1,         0,   0, 0, 0));
    vecs.push_back(mk(0, 0, SEL_JAL,  0, 16'h0,    26'd50,  32'd0,        32'd50,        32'd50,        0,   2, 1, 0));
    vecs.push_back(mk(0, 0, SEL_JR,   0, 16'h0,    26'd0,   32'd7,        32'd7,         32'd7,         0,   0, 0, 1));
    vecs.push_back(mk(0, 0, SEL_JR,   0, 16'h0,    26'd0,   32'hFC000010, 32'hFC000010,  32'hFC000010,  0,   0, 0, 1));
    vecs.push_back(mk(0, 0, SEL_J,    0, 16'h0,    26'd3,   32'd0,        32'hFC000003,  32'hFC000003,  0,   0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // RAS overflow: 9 pushes into 8 entries drop the first return address (2).
    step(1, 0, SEL_SEQ, 0, 16'h0, 26'd0, 32'd0);
    chk("ovf.reset_pc", bus.PC, 32'd1);
    for (int k = 1; k <= 9; k++) begin
      step(0, 0, SEL_JAL, 0, 16'h0, 26'(k * 10), 32'd0);
      chk($sformatf("push%0d.pc", k),  bus.PC, 32'(k * 10));
      chk($sformatf("push%0d.top", k), bus.RasTop, (k == 1) ? 32'd2 : 32'((k - 1) * 10 + 1));
      chk($sformatf("push%0d.cnt", k), 32'(bus.RasCount), (k > 8) ? 32'd8 : 32'(k));
    end
    for (int k = 9; k >= 2; k--) begin
      step(0, 0, SEL_JR, 0, 16'h0, 26'd0, 32'((k - 1) * 10 + 1));
      chk($sformatf("pop%0d.miss", k), 32'(bus.RasMiss), 32'd0);
      chk($sformatf("pop%0d.cnt", k),  32'(bus.RasCount), 32'(k - 2));
    end
    step(0, 0, SEL_JR, 0, 16'h0, 26'd0, 32'd2);
    chk("underflow.miss", 32'(bus.RasMiss), 32'd1);
    chk("underflow.cnt",  32'(bus.RasCount), 32'd0);
    chk("underflow.pc",   bus.PC, 32'd2);
    step(0, 0, SEL_SEQ, 0, 16'h0, 26'd0, 32'd0);
    chk("miss_pulse_clear", 32'(bus.RasMiss), 32'd0);
    chk("after_underflow.pc", bus.PC, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
